// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV64 front end.
// Fetch FSM encoding, canonical NOP and default boot vector.
package riscv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HELD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/if_stage_if_id.sv
// IF/ID pipeline register: flush beats stall beats load; otherwise a bubble.
// One-cycle latency; holds its contents while i_stall is high.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush,
  input  logic        i_stall,
  input  logic        i_load,
  input  logic [31:0] i_instr,
  input  logic [63:0] i_pc,
  input  logic [63:0] i_pc_plus4,
  output logic [31:0] o_instr,
  output logic [63:0] o_pc,
  output logic [63:0] o_pc_plus4,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [63:0] r_pc;
  logic [63:0] r_pc_plus4;
  logic        r_valid;

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_valid    <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
    end else if (i_stall) begin
      r_valid    <= r_valid;
    end else if (i_load) begin
      r_valid    <= 1'b1;
      r_instr    <= i_instr;
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc_plus4;
    end else begin
      r_valid    <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, single-outstanding imem handshake, hold buffer, IF/ID load.
// Zero-latency memory gives one instruction per cycle; stalls park the response in S_HELD.
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] PCnext,
  input  logic        RedirectE,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [63:0] PCF,
  output logic [63:0] PCPlus4F,
  output logic        FetchBusyF,
  output logic [31:0] InstrD,
  output logic [63:0] PCD,
  output logic [63:0] PCPlus4D,
  output logic        ValidD
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic [63:0] r_pcf;
  logic [63:0] r_redir_pc;
  logic [31:0] r_hold_instr;
  logic        r_kill;

  logic        w_in_wait;
  logic        w_in_held;
  logic        w_avail;
  logic        w_advance;
  logic        w_redir_take;
  logic        w_redir_park;
  logic        w_kill_drop;
  logic        w_park;
  logic [63:0] w_pc_plus4;
  logic [31:0] w_instr_f;

  assign w_in_wait    = (r_state == S_WAIT);
  assign w_in_held    = (r_state == S_HELD);
  assign w_avail      = (w_in_wait && imem_valid && !r_kill) || w_in_held;
  assign w_advance    = w_avail && !StallF && !StallD && !RedirectE;
  assign w_redir_take = RedirectE && (w_in_held || (w_in_wait && imem_valid));
  assign w_redir_park = RedirectE && w_in_wait && !imem_valid;
  // A late response to a killed request carries the old PC's word and is dropped.
  assign w_kill_drop  = w_in_wait && imem_valid && r_kill;
  assign w_park       = w_avail && w_in_wait;
  assign w_pc_plus4   = r_pcf + 64'd4;
  assign w_instr_f    = w_in_held ? r_hold_instr : imem_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: w_state_nxt = S_WAIT;
      S_WAIT, S_HELD: begin
        if (w_redir_take || w_redir_park || w_kill_drop || w_advance) begin
          w_state_nxt = S_WAIT;
        end else if (w_park) begin
          w_state_nxt = S_HELD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req = (r_state == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pcf        <= RESET_PC;
      r_kill       <= 1'b0;
      r_redir_pc   <= '0;
      r_hold_instr <= NOP_INSTR;
    end else if (w_redir_take) begin
      r_pcf  <= PCnext;
      r_kill <= 1'b0;
    end else if (w_redir_park) begin
      r_kill     <= 1'b1;
      r_redir_pc <= PCnext;
    end else if (w_kill_drop) begin
      r_pcf  <= r_redir_pc;
      r_kill <= 1'b0;
    end else if (w_advance) begin
      r_pcf <= PCnext;
    end else if (w_park) begin
      r_hold_instr <= imem_rdata;
    end
  end

  if_id_reg u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (FlushD),
    .i_stall    (StallD),
    .i_load     (w_advance),
    .i_instr    (w_instr_f),
    .i_pc       (r_pcf),
    .i_pc_plus4 (w_pc_plus4),
    .o_instr    (InstrD),
    .o_pc       (PCD),
    .o_pc_plus4 (PCPlus4D),
    .o_valid    (ValidD)
  );

  assign imem_addr  = r_pcf;
  assign PCF        = r_pcf;
  assign PCPlus4F   = w_pc_plus4;
  assign FetchBusyF = !w_avail;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a latency-programmable memory model and an IF/ID scoreboard.
module tb_if_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n      = 1'b0;
  logic        RedirectE  = 1'b0;
  logic        StallF     = 1'b0;
  logic        StallD     = 1'b0;
  logic        FlushD     = 1'b0;
  logic [63:0] redir_tgt  = '0;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        imem_valid = 1'b0;
  logic [63:0] PCnext;
  logic        imem_req;
  logic [63:0] imem_addr, PCF, PCPlus4F, PCD, PCPlus4D;
  logic        FetchBusyF, ValidD;
  logic [31:0] InstrD;

  // pc_mux model
  assign PCnext = RedirectE ? redir_tgt : PCPlus4F;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .PCnext(PCnext), .RedirectE(RedirectE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .FetchBusyF(FetchBusyF), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  // Second instance checks address wrap-around at the top of the address space.
  logic        req_w, busy_w, valid_w;
  logic [63:0] addr_w, pcf_w, pcp4f_w, pcd_w, pcp4d_w;
  logic [31:0] instr_w, rdata_w;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h1234_5678;
  endfunction

  assign rdata_w = mem_word(addr_w);

  if_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .PCnext(pcp4f_w), .RedirectE(1'b0),
    .StallF(1'b0), .StallD(1'b0), .FlushD(1'b0),
    .imem_req(req_w), .imem_addr(addr_w), .imem_rdata(rdata_w),
    .imem_valid(req_w), .PCF(pcf_w), .PCPlus4F(pcp4f_w),
    .FetchBusyF(busy_w), .InstrD(instr_w), .PCD(pcd_w),
    .PCPlus4D(pcp4d_w), .ValidD(valid_w)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: response after mem_lat wait cycles, evaluated just after the falling edge.
  int mem_lat = 0;
  int cnt     = 0;
  always @(negedge clk) begin
    #1;
    if (rst_n && imem_req) begin
      imem_valid = (cnt >= mem_lat);
      imem_rdata = mem_word(imem_addr);
    end else begin
      imem_valid = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
    end
  end
  always @(posedge clk) begin
    if (!rst_n || !imem_req || imem_valid) cnt <= 0;
    else cnt <= cnt + 1;
  end

  // Scoreboard
  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } exp_t;
  exp_t exp_q[$];

  function automatic exp_t mk(input logic [31:0] i, input logic [63:0] p);
    exp_t e;
    e.instr = i;
    e.pc    = p;
    return e;
  endfunction

  logic ld_chk = 1'b0;
  always @(posedge clk) ld_chk <= rst_n && !StallD && !FlushD;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (ld_chk && ValidD) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_delivery: got InstrD %h PCD %h, required none", InstrD, PCD);
        end else begin
          e = exp_q.pop_front();
          chk("sb_InstrD", {32'h0, InstrD}, {32'h0, e.instr});
          chk("sb_PCD", PCD, e.pc);
          chk("sb_PCPlus4D", PCPlus4D, e.pc + 64'd4);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    exp_q.push_back(mk(32'h9234_5678, 64'h8000_0000));
    exp_q.push_back(mk(32'h9234_567C, 64'h8000_0004));
    exp_q.push_back(mk(32'h9234_5670, 64'h8000_0008));
    exp_q.push_back(mk(32'h9234_5674, 64'h8000_000C));

    repeat (3) step();
    #2;
    chk("rst_PCF", PCF, 64'h8000_0000);
    chk("rst_imem_req", {63'h0, imem_req}, 64'h0);
    chk("rst_ValidD", {63'h0, ValidD}, 64'h0);
    chk("rst_InstrD", {32'h0, InstrD}, {32'h0, NOP_INSTR});
    chk("rst_PCD", PCD, 64'h0);
    chk("rst_PCPlus4D", PCPlus4D, 64'h0);
    chk("rst_busy", {63'h0, FetchBusyF}, 64'h1);
    chk("wrap_rst_PCF", pcf_w, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_PCPlus4F", pcp4f_w, 64'h0);
    rst_n = 1'b1;

    step(); #2;
    chk("addr0", imem_addr, 64'h8000_0000);
    chk("req0", {63'h0, imem_req}, 64'h1);
    step(); #2;
    chk("addr1", imem_addr, 64'h8000_0004);
    chk("wrap_next_addr", addr_w, 64'h0);
    chk("wrap_InstrD", {32'h0, instr_w}, 64'hEDCB_A984);
    chk("wrap_PCD", pcd_w, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_PCPlus4D", pcp4d_w, 64'h0);
    step(); #2;
    chk("addr2", imem_addr, 64'h8000_0008);

    // Switch to a 3-cycle memory; the 0C fetch now waits.
    step();
    mem_lat = 3;
    #2;
    chk("addr3", imem_addr, 64'h8000_000C);
    chk("wait_busy", {63'h0, FetchBusyF}, 64'h1);
    step(); step(); step();
    StallF = 1'b1;
    StallD = 1'b1;
    #2;
    chk("resp_avail", {63'h0, FetchBusyF}, 64'h0);
    step(); #2;
    chk("held_req", {63'h0, imem_req}, 64'h0);
    chk("held_avail", {63'h0, FetchBusyF}, 64'h0);
    step();
    StallF = 1'b0;
    StallD = 1'b0;
    #2;
    chk("held_req2", {63'h0, imem_req}, 64'h0);
    step(); #2;
    chk("no_dup_addr", imem_addr, 64'h8000_0010);
    chk("no_dup_req", {63'h0, imem_req}, 64'h1);

    // Redirect while the request to 10 is outstanding.
    RedirectE = 1'b1;
    redir_tgt = 64'h8000_0100;
    step();
    RedirectE = 1'b0;
    #2;
    chk("kill_bubble", {63'h0, ValidD}, 64'h0);
    chk("kill_addr_stable", imem_addr, 64'h8000_0010);
    step(); step(); #2;
    chk("stale_busy", {63'h0, FetchBusyF}, 64'h1);
    step();
    mem_lat = 0;
    exp_q.push_back(mk(32'h9234_5778, 64'h8000_0100));
    #2;
    chk("redir_addr", imem_addr, 64'h8000_0100);
    chk("stale_ValidD", {63'h0, ValidD}, 64'h0);

    // Redirect coincident with a response: the 104 word must not be delivered.
    step();
    RedirectE = 1'b1;
    redir_tgt = 64'h8000_0200;
    step();
    RedirectE = 1'b0;
    exp_q.push_back(mk(32'h9234_5478, 64'h8000_0200));
    #2;
    chk("redir_same_addr", imem_addr, 64'h8000_0200);
    chk("redir_same_ValidD", {63'h0, ValidD}, 64'h0);

    // Flush together with stall.
    step();
    FlushD = 1'b1;
    StallD = 1'b1;
    exp_q.push_back(mk(32'h9234_547C, 64'h8000_0204));
    step();
    FlushD = 1'b0;
    StallD = 1'b0;
    #2;
    chk("flush_InstrD", {32'h0, InstrD}, 64'h0000_0013);
    chk("flush_ValidD", {63'h0, ValidD}, 64'h0);
    chk("flush_PCD", PCD, 64'h0);
    chk("flush_PCPlus4D", PCPlus4D, 64'h0);
    chk("flush_req", {63'h0, imem_req}, 64'h0);

    // Reset in the middle of a request.
    step();
    rst_n = 1'b0;
    step(); #2;
    chk("rst2_PCF", PCF, 64'h8000_0000);
    chk("rst2_req", {63'h0, imem_req}, 64'h0);
    chk("rst2_ValidD", {63'h0, ValidD}, 64'h0);
    repeat (2) step();
    chk("sb_drained", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage RV64 pipeline. Holds the fetch program counter and runs a single-outstanding request/valid handshake to instruction memory. Loads the IF/ID pipeline register. Consumes `PCnext` from `pc_mux` and produces `PCPlus4F`, which feeds back into `pc_mux`. Handles stalls, flushes and execute-stage redirects that arrive while a memory request is still outstanding.

## Interface
Parameters:
- `RESET_PC`, default `64'h0000_0000_8000_0000`: PCF value after reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `PCnext`  in  64  next PC from `pc_mux`.
- `RedirectE`  in  1  execute-stage redirect; equals (`PCSrcE != 2'b00`).
- `StallF`, `StallD`  in  1 each  hazard-unit stalls.
- `FlushD`  in  1  hazard-unit flush of IF/ID.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  64  fetch address; equals PCF.
- `imem_rdata`  in  32  instruction word; valid only when `imem_valid`=1.
- `imem_valid`  in  1  response strobe; may assert in the same cycle as `imem_req`.
- `PCF`, `PCPlus4F`  out  64 each  fetch PC, and PCF+4.
- `FetchBusyF`  out  1  front end has no instruction to deliver this cycle.
- `InstrD`  out  32  IF/ID instruction.
- `PCD`, `PCPlus4D`  out  64 each  IF/ID PC and PC+4.
- `ValidD`  out  1  IF/ID holds a real instruction.

## Operation
- States: `S_IDLE`, `S_WAIT`, `S_HELD`.
  - `S_IDLE`: no request; next state is `S_WAIT` unconditionally.
  - `S_WAIT`: `imem_req`=1; address stays stable until `imem_valid`.
  - `S_HELD`: response is parked in the hold buffer; `imem_req`=0.
- `kill` flag and `RedirPC` register support a redirect while a request is outstanding.
- Instruction available (`avail`) when either condition holds:
  - `S_WAIT` with `imem_valid`=1 and `kill`=0.
  - `S_HELD`.
- `advance` = `avail` & !`StallF` & !`StallD` & !`RedirectE`.
- PCF update rules, in priority order:
  1. `RedirectE`=1 in `S_HELD`, or in `S_WAIT` with `imem_valid`=1: PCF<=PCnext, buffer dropped, `kill`<=0, next state `S_WAIT`.
  2. `RedirectE`=1 in `S_WAIT` with `imem_valid`=0: `kill`<=1, `RedirPC`<=PCnext, stay in `S_WAIT`. A later redirect before the response overwrites `RedirPC`.
  3. `S_WAIT` with `imem_valid`=1 and `kill`=1: response discarded, PCF<=`RedirPC`, `kill`<=0, stay in `S_WAIT`.
  4. `advance`: PCF<=PCnext, next state `S_WAIT`.
  5. `avail` but stalled, in `S_WAIT`: `imem_rdata` captured into the hold buffer, next state `S_HELD`.
  6. Otherwise: hold.
- `RedirectE` overrides `StallF`.
- IF/ID register priority:
  1. `FlushD`: `ValidD`<=0, `InstrD`<=NOP (`32'h0000_0013`), `PCD`/`PCPlus4D`<=0.
  2. `StallD`: hold.
  3. `advance`: load the instruction (from `imem_rdata` or the hold buffer), PCF and PCPlus4F; `ValidD`<=1.
  4. Otherwise: bubble, same values as the flush case.
- Arithmetic: PCPlus4F = PCF + 4, modulo 2^64. Address `64'hFFFF_FFFF_FFFF_FFFC` wraps to 0.
- `FetchBusyF` = !`avail`.

## Timing
- Reset values:
  - PCF = `RESET_PC`; state `S_IDLE`; `kill`=0.
  - `imem_req`=0.
  - `ValidD`=0, `InstrD`=NOP, `PCD`=0, `PCPlus4D`=0.
- First request is issued in the first cycle after `rst_n` goes high.
- `imem_req` is decoded from the registered state only, with no combinational path from inputs.
- With a zero-latency memory and no stalls: one instruction per cycle; `InstrD` appears one cycle after PCF is presented.
- With an N-cycle memory: one instruction per N+1 cycles.
- Reset mid-request drops the outstanding transaction. The memory must not return a response after reset.
- `PCPlus4F` is combinational from PCF.

## Structure
- `riscv_pkg` holds:
  - `fetch_state_t` enum.
  - `NOP_INSTR` = `32'h0000_0013`.
  - `DEFAULT_RESET_PC`.
- Sub-module `if_id_reg`: IF/ID register with flush and stall.
- The FSM, PC register and hold buffer stay in `if_stage`.

## Test plan
- Reset, then a zero-latency memory with no stalls: `imem_addr` sequence `80000000`, `80000004`, `80000008`; `ValidD`=1 from the second post-reset cycle.
- 3-cycle memory with `StallF`=`StallD`=1 for 2 cycles after the response: enters `S_HELD`, `imem_req`=0; after release, `InstrD` equals the held word and there is no duplicate fetch.
- `RedirectE` with PCnext=`80000100` while waiting with `imem_valid`=0:
  - the stale response arrives and is discarded with `ValidD`=0;
  - next `imem_addr`=`80000100`.
- `RedirectE` and `imem_valid` in the same cycle: PCF<=PCnext and the fetched word is not delivered.
- `FlushD` together with `StallD`: flush wins and `InstrD`=`00000013`.
- `RESET_PC`=`FFFF_FFFF_FFFF_FFFC`: `PCPlus4F`=0 and the next fetch address is 0.
